mix_columns_iter: RTL and testbench
===================================

// Module: mix_columns_iter
// PURPOSE
//  Iterative forward AES MixColumns engine; the encrypt-path counterpart to inverse MixColumns.
//  Accepts a 128-bit AES state over a valid/ready handshake.
//  Transforms COLS_PER_CYCLE columns per clock in an internal state register.
//  Returns the result over a valid/ready handshake; sits between ShiftRows and AddRoundKey in the round datapath.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns mixed per BUSY cycle; legal values 1, 2 or 4 (elaboration error otherwise)
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    reset, synchronous, active-high
//  in_valid   in   1    in_data valid
//  in_ready   out  1    engine can accept a state
//  in_data    in   128  state; column c = in_data[127-32c -: 32], byte r of column = bits [31-8r -: 8]
//  out_valid  out  1    out_data holds a completed result
//  out_ready  in   1    consumer accepts out_data
//  out_data   out  128  MixColumns(in_data), same column/byte layout
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): FSM->IDLE, column counter 0, data register 0; out_valid=0, out_data=0, in_ready=1.
//  - FSM states, IDLE/BUSY/DONE:
//    IDLE: in_ready=1. in_valid&in_ready -> latch in_data, cnt=0, go BUSY.
//    BUSY: in_ready=0. Each cycle replace columns cnt..cnt+COLS_PER_CYCLE-1 with mixed values; cnt += COLS_PER_CYCLE.
//      Go DONE on the cycle that processes column 3. Columns are processed 0 first, i.e. MSW first.
//    DONE: out_valid=1, out_data = data register (stable while stalled); out_ready=1 -> IDLE.
//  - Latency: acceptance edge N -> out_valid high after edge N+4/COLS_PER_CYCLE.
//    No accept in DONE; throughput = one state per 4/COLS_PER_CYCLE + 2 cycles minimum.
//  - Per column {b0,b1,b2,b3} with b0 = MSB:
//    m0=2b0^3b1^b2^b3; m1=b0^2b1^3b2^b3; m2=b0^b1^2b2^3b3; m3=3b0^b1^b2^2b3.
//  - GF(2^8) rules: 2x = {x[6:0],0} ^ (8'h1b & {8{x[7]}}); 3x = 2x ^ x. All byte arithmetic is XOR, no carries.
//  - Counter is 2 bits and wraps 3->0; it is reset to 0 on every accept.
//  - in_valid while BUSY/DONE: ignored, no side effect. Source must hold in_data until in_ready=1.
//  - out_ready while not DONE: ignored. out_valid must not drop without out_ready.
//  - rst asserted mid-BUSY or mid-DONE: work abandoned, outputs to reset values next edge, no partial result emitted.
//  - in_data is sampled only on the accept edge; later changes do not affect the result.
// STRUCTURE
//  - Shared package aes_pkg:
//    gm2/gm3 functions; AES_POLY=8'h1b; typedef aes_state_t [127:0]; typedef aes_word_t [31:0];
//    mix_fsm_e {IDLE,BUSY,DONE}.
//  - Sub-module mix_column_word (32-bit comb column mixer):
//    instantiated COLS_PER_CYCLE times, fed by a cnt-indexed column mux;
//    the decrypt side can later share the package GF helpers.
//  - This file: FSM, counter, data register, handshake logic only.
// TESTING
//  1. Reset: rst high 2 cycles -> in_ready=1, out_valid=0, out_data=0.
//  2. FIPS-197 column vectors in_data={db135345,f20a225c,01010101,c6c6c6c6} -> out_data={8e4da1bc,9fdc589d,01010101,c6c6c6c6};
//     out_valid exactly 4 cycles after accept (COLS_PER_CYCLE=1), 1 cycle (=4).
//  3. in_data={d4d4d4d5,2d26314c,00000000,ffffffff} -> {d5d5d7d6,4d7ebdf8,00000000,ffffffff}.
//     Also check that in_data changed while BUSY is not used.
//  4. Backpressure: out_ready=0 for 10 cycles in DONE.
//     -> out_valid held, out_data stable, in_ready=0, new in_valid not accepted.
//     out_ready=1 -> IDLE next cycle.
//  5. rst pulsed on 2nd BUSY cycle -> next cycle out_valid=0, in_ready=1, out_data=0.
//     A subsequent state computes correctly.
//  6. Back-to-back 1000 random states at random in_valid/out_ready -> every result matches the golden model, in order.
//     Run for COLS_PER_CYCLE = 1, 2, 4.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns engines.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mix_fsm_e;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (AES_POLY & {8{x[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward MixColumns of one 32-bit column, byte 0 in the MSBs.
module mix_column_word import aes_pkg::*; (
  input  aes_word_t col_i,
  output aes_word_t col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col_i;

  assign col_o = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                  b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                  b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                  gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: latches a state, mixes COLS_PER_CYCLE columns per
// cycle in place (column 0 first), then holds the result until consumed.
module mix_columns_iter import aes_pkg::*; #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // With 4 columns per cycle the step truncates to 0, which is harmless:
  // the single BUSY cycle is also the last one.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

  mix_fsm_e   state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t data_q, data_d;
  logic       last_step;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  aes_word_t  col_in  [COLS_PER_CYCLE];
  aes_word_t  col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = data_q[127 - 32*col_idx[g] -: 32];

    mix_column_word u_mix (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  assign last_step = (cnt_q + LAST_OFS) == 2'd3;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++)
          data_d[127 - 32*col_idx[g] -: 32] = col_out[g];
        cnt_d = cnt_q + STEP;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // Partially mixed contents never leave the block.
  assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and randomized checks of mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_mix_columns_iter;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] out_data  [3];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k])
    );
  end

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      r[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present d until accepted; returns just after the accept edge.
  task automatic send(input int k, input logic [127:0] d);
    int n = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 50) begin tick(); n++; end
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 50) begin tick(); lat++; end
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_data[k] !== '0)
        $display("FAIL reset[%0d] in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                 k, in_ready[k], out_valid[k], out_data[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fips(input int k);
    int lat;
    send(k, V1);
    wait_out(k, lat);
    chk_cnt++;
    if (lat !== (4 >> k)) $display("FAIL latency[%0d] got %0d want %0d", k, lat, 4 >> k);
    else pass_cnt++;
    chk_cnt++;
    if (out_data[k] !== E1) $display("FAIL fips[%0d] got %h want %h", k, out_data[k], E1);
    else pass_cnt++;
    drain(k);
    chk_cnt++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1)
      $display("FAIL fips_idle[%0d] out_valid=%b in_ready=%b want 0 1", k, out_valid[k], in_ready[k]);
    else pass_cnt++;
  endtask

  task automatic test_hold_input(input int k);
    int lat;
    send(k, V2);
    // Garbage offered while busy must be neither used nor accepted.
    in_data[k]  = 128'h0123456789abcdef_fedcba9876543210;
    in_valid[k] = 1'b1;
    wait_out(k, lat);
    in_valid[k] = 1'b0;
    chk_cnt++;
    if (out_data[k] !== E2) $display("FAIL vec2[%0d] got %h want %h", k, out_data[k], E2);
    else pass_cnt++;
    drain(k);
    chk_cnt++;
    if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0)
      $display("FAIL vec2_idle[%0d] in_ready=%b out_valid=%b want 1 0", k, in_ready[k], out_valid[k]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure(input int k);
    int lat;
    int bad = 0;
    send(k, V1);
    wait_out(k, lat);
    in_data[k]  = V2;
    in_valid[k] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid[k] !== 1'b1 || out_data[k] !== E1 || in_ready[k] !== 1'b0) bad++;
      tick();
    end
    in_valid[k] = 1'b0;
    chk_cnt++;
    if (bad != 0) $display("FAIL stall[%0d] %0d bad cycles, last out_valid=%b out_data=%h in_ready=%b want 1 %h 0",
                           k, bad, out_valid[k], out_data[k], in_ready[k], E1);
    else pass_cnt++;
    drain(k);
    chk_cnt++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1)
      $display("FAIL stall_release[%0d] out_valid=%b in_ready=%b want 0 1", k, out_valid[k], in_ready[k]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid(input int k);
    int lat;
    send(k, V1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_data[k] !== '0)
      $display("FAIL mid_reset[%0d] out_valid=%b in_ready=%b out_data=%h want 0 1 0",
               k, out_valid[k], in_ready[k], out_data[k]);
    else pass_cnt++;
    send(k, V2);
    wait_out(k, lat);
    chk_cnt++;
    if (out_data[k] !== E2 || lat !== (4 >> k))
      $display("FAIL after_reset[%0d] got %h lat %0d want %h lat %0d", k, out_data[k], lat, E2, 4 >> k);
    else pass_cnt++;
    drain(k);
  endtask

  task automatic test_back_to_back(input int k);
    logic [127:0] exp_q[$];
    logic [127:0] want;
    int sent = 0, got = 0, cyc = 0;
    bit pending = 0;
    while (got < 1000 && cyc < 30000) begin
      if (!pending && sent < 1000 && $urandom_range(3) != 0) begin
        in_data[k] = {$urandom, $urandom, $urandom, $urandom};
        pending    = 1;
      end
      in_valid[k]  = pending;
      out_ready[k] = $urandom_range(1) != 0;
      if (in_valid[k] && in_ready[k]) begin
        exp_q.push_back(model(in_data[k]));
        sent++;
        pending = 0;
      end
      if (out_valid[k] && out_ready[k]) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk_cnt++;
        if (out_data[k] !== want) $display("FAIL random[%0d] #%0d got %h want %h", k, got, out_data[k], want);
        else pass_cnt++;
        got++;
      end
      tick();
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    chk_cnt++;
    if (got != 1000) $display("FAIL random_count[%0d] got %0d want 1000", k, got);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = '0;
    end
    test_reset();
    for (int k = 0; k < 3; k++) begin
      test_fips(k);
      test_hold_input(k);
      test_backpressure(k);
      test_reset_mid(k);
      test_back_to_back(k);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
